// File: rtl/isram_loader.sv
// Streams IN_W-bit words into WORDS_PER_ROW-word rows and writes each
// completed row to the I-SRAM at consecutive addresses 0..last_row.
`timescale 1ns/1ps
module isram_loader #(
  parameter int IN_W          = 16,
  parameter int WORDS_PER_ROW = 15,
  parameter int ROW_W         = 240,
  parameter int ADDR_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_row,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              in_ready,
  output logic              iMem_WEPin,
  output logic [ADDR_W-1:0] iMem_WEAddress,
  output logic [ROW_W-1:0]  idataWrite,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    word_cnt;
  logic [ADDR_W-1:0]   row_addr;
  logic [ADDR_W-1:0]   last_row_q;
  logic [ROW_W-1:0]    row_reg;
  logic [ROW_W-1:0]    row_next;
  logic                accept;
  logic                row_full;

  assign in_ready   = (state == FILL);
  assign iMem_WEPin = (state == WRITE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  assign accept   = in_valid && in_ready;
  assign row_full = accept && (word_cnt == LAST_WORD);

  always_comb begin
    row_next = row_reg;
    for (int unsigned k = 0; k < WORDS_PER_ROW; k++) begin
      if (word_cnt == CNT_W'(k)) row_next[k*IN_W +: IN_W] = in_data;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FILL;
      FILL:    if (row_full) state_next = WRITE;
      WRITE:   state_next = (row_addr == last_row_q) ? DONE : FILL;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Write address/data are staged on the final accept so they are valid
  // throughout WRITE and simply hold afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt       <= '0;
      row_addr       <= '0;
      last_row_q     <= '0;
      row_reg        <= '0;
      iMem_WEAddress <= '0;
      idataWrite     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_addr   <= '0;
            word_cnt   <= '0;
            last_row_q <= last_row;
          end
        end
        FILL: begin
          if (accept) begin
            row_reg <= row_next;
            if (row_full) begin
              word_cnt       <= '0;
              iMem_WEAddress <= row_addr;
              idataWrite     <= row_next;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (row_addr != last_row_q) row_addr <= row_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_isram_loader.sv
// Bench for isram_loader: a control-vector table, then multi-row loads with
// expected rows rebuilt from the driven word list.
`timescale 1ns/1ps
module tb_isram_loader;
  localparam int IN_W   = 16;
  localparam int WPR    = 15;
  localparam int ROW_W  = 240;
  localparam int ADDR_W = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] last_row = '0;
  logic              in_valid = 1'b0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_ready, iMem_WEPin, busy, done;
  logic [ADDR_W-1:0] iMem_WEAddress;
  logic [ROW_W-1:0]  idataWrite;

  int checks = 0;
  int errors = 0;
  int we_total = 0;
  int exp_we_total = 0;

  localparam logic [ROW_W-1:0] SEQ_ROW =
    240'h000F_000E_000D_000C_000B_000A_0009_0008_0007_0006_0005_0004_0003_0002_0001;

  always #5 clock = ~clock;

  isram_loader #(
    .IN_W(IN_W), .WORDS_PER_ROW(WPR), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .last_row(last_row),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .iMem_WEPin(iMem_WEPin), .iMem_WEAddress(iMem_WEAddress),
    .idataWrite(idataWrite), .busy(busy), .done(done)
  );

  always @(negedge clock) if (iMem_WEPin === 1'b1) we_total++;

  task automatic check(input string name, input logic [ROW_W-1:0] act,
                       input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // {in_ready, iMem_WEPin, busy, done}
  task automatic check_ctrl(input string tag, input logic [3:0] exp);
    check({tag, " ctrl"}, ROW_W'({in_ready, iMem_WEPin, busy, done}), ROW_W'(exp));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_abort();
    reset = 1'b1; start = 1'b1; in_valid = 1'b1;
    last_row = 8'($urandom); in_data = 16'($urandom);
    step();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    check_ctrl("abort", 4'b0000);
    check("abort addr", ROW_W'(iMem_WEAddress), '0);
    check("abort data", idataWrite, '0);
    step();
    check_ctrl("abort idle", 4'b0000);
    check("abort we_count", ROW_W'(we_total), ROW_W'(exp_we_total));
  endtask

  // One load of rows 0..lr. Word values are either sequential (15*r+k+1) or
  // random; the expected row is packed from the words actually offered.
  task automatic run_load(input int lr, input bit seq_data, input int gap_k,
                          input int gap_n, input bit rand_gaps, input int stray_row,
                          input int abort_row, input int abort_k);
    logic [ROW_W-1:0] exp_row;
    logic [IN_W-1:0]  w;
    start = 1'b1; last_row = 8'(lr);
    in_valid = 1'($urandom_range(1)); in_data = 16'($urandom);
    step();
    start = 1'b0; last_row = 8'($urandom);
    check_ctrl("start", 4'b1010);
    exp_row = '0;
    for (int r = 0; r <= lr; r++) begin
      exp_row = '0;
      for (int k = 0; k < WPR; k++) begin
        int n;
        n = 0;
        if (k == gap_k) n = gap_n;
        else if (rand_gaps && $urandom_range(3) == 0) n = int'($urandom_range(2, 1));
        for (int g = 0; g < n; g++) begin
          in_valid = 1'b0; in_data = 16'($urandom);
          step();
          check_ctrl("gap", 4'b1010);
        end
        w = seq_data ? 16'(WPR*r + k + 1) : 16'($urandom);
        exp_row[k*IN_W +: IN_W] = w;
        in_valid = 1'b1; in_data = w;
        if (r == stray_row && k == 5) begin start = 1'b1; last_row = 8'd5; end
        step();
        start = 1'b0;
        if (r == abort_row && k == abort_k) begin do_abort(); return; end
        if (k < WPR-1) check_ctrl("fill", 4'b1010);
      end
      exp_we_total++;
      check_ctrl("write", 4'b0110);
      check("write addr", ROW_W'(iMem_WEAddress), ROW_W'(r));
      check("write data", idataWrite, exp_row);
      in_valid = 1'($urandom_range(1)); in_data = 16'($urandom);
      if (r == abort_row && abort_k == WPR) begin do_abort(); return; end
      step();
      if (r < lr) check_ctrl("next row", 4'b1010);
    end
    check_ctrl("done", 4'b0011);
    start = 1'b1; last_row = 8'($urandom); in_valid = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b0;
    check_ctrl("idle after done", 4'b0000);
    check("hold addr", ROW_W'(iMem_WEAddress), ROW_W'(lr));
    check("hold data", idataWrite, exp_row);
    check("we_count", ROW_W'(we_total), ROW_W'(exp_we_total));
  endtask

  typedef struct {
    logic              rst;
    logic              st;
    logic [ADDR_W-1:0] lr;
    logic              v;
    logic [IN_W-1:0]   d;
    logic [3:0]        exp_ctrl;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 16'h0000, 4'b0000};
    tbl[1] = '{1'b0, 1'b0, 8'd0, 1'b1, 16'h1234, 4'b0000};
    tbl[2] = '{1'b0, 1'b0, 8'd3, 1'b1, 16'h4321, 4'b0000};
    tbl[3] = '{1'b0, 1'b1, 8'd0, 1'b1, 16'h5555, 4'b1010};
    tbl[4] = '{1'b0, 1'b1, 8'd7, 1'b1, 16'hAAAA, 4'b1010};
    tbl[5] = '{1'b1, 1'b1, 8'd2, 1'b1, 16'hBBBB, 4'b0000};
    tbl[6] = '{1'b0, 1'b0, 8'd0, 1'b1, 16'h7777, 4'b0000};

    for (int i = 0; i < 7; i++) begin
      reset = tbl[i].rst; start = tbl[i].st; last_row = tbl[i].lr;
      in_valid = tbl[i].v; in_data = tbl[i].d;
      step();
      check_ctrl($sformatf("vec%0d", i), tbl[i].exp_ctrl);
      check($sformatf("vec%0d addr", i), ROW_W'(iMem_WEAddress), '0);
      check($sformatf("vec%0d data", i), idataWrite, '0);
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;

    // single row, sequential words, back-to-back
    run_load(0, 1'b1, -1, 0, 1'b0, -1, -1, -1);
    check("single row literal", idataWrite, SEQ_ROW);
    // same load with a 3-cycle hole between words 7 and 8
    run_load(0, 1'b1, 7, 3, 1'b0, -1, -1, -1);
    check("gap row literal", idataWrite, SEQ_ROW);
    // start pulsed during row 2 must not relatch last_row
    run_load(9, 1'b0, -1, 0, 1'b1, 2, -1, -1);
    // reset after word 10 of row 1, then a fresh single-row load
    run_load(3, 1'b0, -1, 0, 1'b0, -1, 1, 9);
    run_load(0, 1'b0, -1, 0, 1'b0, -1, -1, -1);
    // reset landing on a WRITE cycle
    run_load(3, 1'b0, -1, 0, 1'b1, -1, 2, WPR);
    // randomized short loads
    for (int i = 0; i < 6; i++)
      run_load(int'($urandom_range(12)), 1'b0, -1, 0, 1'b1,
               int'($urandom_range(12)), -1, -1);
    // all 256 rows
    run_load(255, 1'b0, -1, 0, 1'b1, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
